uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bus for uart_rx: line and parity select in, received byte and status out.
interface uart_rx_if;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  modport master (
    output rx_in, parity_type,
    input  data_out, data_valid, parity_error, framing_error, busy
  );

  modport slave (
    input  rx_in, parity_type,
    output data_out, data_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional odd/even parity, one stop bit.
// Define UART_RX_SYNC_EN to pass rx_in through a 2-flop synchronizer (+2 cycles latency).
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic          armed;
  logic [1:0]    ptype;
  logic [7:0]    shift_q;
  logic          par_bit;
  logic          rx_s;
  logic          start_det;
  logic          tick;
  logic          exp_par;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.rx_in};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = bus.rx_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    // NOTE: all clocked state uses <= so every flop sees pre-edge values of its peers.
    else     state <= state_n;
  end

  // tick marks a sample edge: mid-start after half a bit, then every full bit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n   = state;
    start_det = 1'b0;
    tick      = 1'b0;
    case (state)
      IDLE: if (armed && !rx_s) begin
        state_n   = START;
        start_det = 1'b1;
      end
      START: if (cnt == HALF_M1) begin
        tick    = 1'b1;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_M1) begin
        tick = 1'b1;
        if (bit_cnt == 3'd7) state_n = (ptype != 2'b00) ? PARITY : STOP;
      end
      PARITY: if (cnt == FULL_M1) begin
        tick    = 1'b1;
        state_n = STOP;
      end
      STOP: if (cnt == FULL_M1) begin
        tick    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      armed   <= 1'b0;
      ptype   <= 2'b00;
      shift_q <= 8'h00;
      par_bit <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (start_det) begin
        armed   <= 1'b0;
        bit_cnt <= '0;
        ptype   <= bus.parity_type;
        par_bit <= 1'b0;
      end else if (state == IDLE && rx_s) begin
        armed <= 1'b1;
      end
      if (state == DATA && tick) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY && tick) par_bit <= rx_s;
    end
  end

  // Odd parity expects a 1 when the data popcount is even; even parity the reverse.
  assign exp_par = (ptype == 2'b10) ? ^shift_q : ~^shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out      <= 8'h00;
      bus.data_valid    <= 1'b0;
      bus.parity_error  <= 1'b0;
      bus.framing_error <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      if (state == STOP && tick) begin
        bus.data_out      <= shift_q;
        bus.data_valid    <= 1'b1;
        bus.parity_error  <= (ptype == 2'b00) ? 1'b0 : (par_bit ^ exp_par);
        bus.framing_error <= ~rx_s;
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames with a scoreboard, plus glitch,
// framing-recovery and mid-frame reset sequences.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at_cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0] pt;
    logic [1:0] pt_mid;
    logic [7:0] d;
    logic       pbit;
    logic       sbit;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every data_valid must match the oldest expected frame and cycle.
  always @(negedge clk) begin
    if (!rst && bus.data_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", {24'h0, bus.data_out}, {24'h0, e.data});
        check("parity_error", {31'h0, bus.parity_error}, {31'h0, e.perr});
        check("framing_error", {31'h0, bus.framing_error}, {31'h0, e.ferr});
        check("valid_latency", cyc, e.at_cyc);
      end
    end
  end

  // Drives one frame starting just after a rising edge; the line then stays at the stop
  // level for gap cycles, busy is checked low, and the line returns idle high.
  task automatic send_frame(input logic [1:0] pt, input logic [1:0] pt_mid,
                            input logic [7:0] d, input logic pbit, input logic sbit,
                            input logic [7:0] e_data, input logic e_perr,
                            input logic e_ferr, input int gap);
    int   c0;
    exp_t e;
    bus.parity_type = pt;
    @(posedge clk); #1;
    c0 = cyc;
    e.data   = e_data;
    e.perr   = e_perr;
    e.ferr   = e_ferr;
    e.at_cyc = c0 + 1 + LAT + CPB / 2 + CPB * ((pt != 2'b00) ? 10 : 9);
    sb.push_back(e);
    bus.rx_in = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 bus.rx_in = d[i];
      if (i == 4) bus.parity_type = pt_mid;
      repeat (CPB) @(posedge clk);
    end
    if (pt != 2'b00) begin
      #1 bus.rx_in = pbit;
      repeat (CPB) @(posedge clk);
    end
    #1 bus.rx_in = sbit;
    repeat (CPB + gap) @(posedge clk);
    #1;
    check("busy_after_frame", {31'h0, bus.busy}, 0);
    bus.rx_in = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{2'b00, 2'b00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 2'b01, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 2'b01, 8'h03, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{2'b10, 2'b00, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 2'b10, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 2'b11, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 2'b10, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 2'b01, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{2'b00, 2'b00, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};

    bus.rx_in       = 1'b1;
    bus.parity_type = 2'b00;
    rst             = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_out", {24'h0, bus.data_out}, 0);
    check("rst_data_valid", {31'h0, bus.data_valid}, 0);
    check("rst_flags", {30'h0, bus.parity_error, bus.framing_error}, 0);
    check("rst_busy", {31'h0, bus.busy}, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 9; i++)
      send_frame(vecs[i].pt, vecs[i].pt_mid, vecs[i].d, vecs[i].pbit, vecs[i].sbit,
                 vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr, 2);

    // Back-to-back frames with no idle gap beyond the stop bit.
    send_frame(2'b00, 2'b00, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 0);
    send_frame(2'b00, 2'b00, 8'h34, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 0);

    // Short low glitch: start is detected, then rejected at the start sample.
    @(posedge clk); #1;
    bus.rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.rx_in = 1'b1;
    check("glitch_busy_high", {31'h0, bus.busy}, 1);
    repeat (CPB) @(posedge clk);
    #1;
    check("glitch_busy_low", {31'h0, bus.busy}, 0);
    check("glitch_data_held", {24'h0, bus.data_out}, 32'h34);
    repeat (4) @(posedge clk);

    // Framing error, line held low 3 bit times, then a clean frame.
    send_frame(2'b00, 2'b00, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 3 * CPB);
    send_frame(2'b00, 2'b00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 2);

    // Leave both flags set, then reset in the middle of data bit 3 of 0xFF.
    send_frame(2'b01, 2'b01, 8'h96, 1'b0, 1'b0, 8'h96, 1'b1, 1'b1, 2);
    check("flags_before_rst", {30'h0, bus.parity_error, bus.framing_error}, 3);
    @(posedge clk); #1;
    bus.rx_in = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 bus.rx_in = 1'b1;
    repeat (3 * CPB + CPB / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_data_out", {24'h0, bus.data_out}, 0);
    check("midrst_valid", {31'h0, bus.data_valid}, 0);
    check("midrst_flags", {30'h0, bus.parity_error, bus.framing_error}, 0);
    check("midrst_busy", {31'h0, bus.busy}, 0);
    repeat (6 * CPB) @(posedge clk);
    send_frame(2'b10, 2'b10, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 2);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
